butterfly_r2_param: RTL

Parametrised radix-2 butterfly for the FFT datapath, the successor to the fixed-width butterfly_4.
- Computes sum = up+down and diff = up−down. The diff is then rotated by one of four trivial twiddles: 1, −i, −1, +i.
- Optional per-sample divide-by-2 with round-half-up, then saturation back to DW bits.
- Both outputs share one fixed latency LAT; no skew between the add and sub paths.
- Adds a sticky overflow flag, a saturation event counter and a pipeline flush.

---
 rtl/butterfly_r2_param_pkg.sv | 39 +++
 rtl/butterfly_r2_param_core.sv | 63 ++++++
 rtl/pipe_reg.sv | 40 ++++
 rtl/butterfly_r2_param.sv | 122 ++++++++++++
 4 files changed

// File: rtl/butterfly_r2_param_pkg.sv
// Shared FFT definitions: twiddle rotation encoding, the fixed-width data bus,
// and a width-generic round/saturate helper.
package butterfly_r2_param_pkg;

    typedef enum logic [1:0] {
        ROT_P1 = 2'd0,
        ROT_NI = 2'd1,
        ROT_N1 = 2'd2,
        ROT_PI = 2'd3
    } rot_e;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } FFT_DATA_BUS;

    localparam int SAT_MAXW = 64;

    // Returns {clamped, value}; value is sign-extended to SAT_MAXW bits.
    function automatic logic [SAT_MAXW:0] round_sat(
        input logic signed [SAT_MAXW-1:0] v,
        input logic                       scale,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] vs;
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        vs = scale ? ((v + 64'sd1) >>> 1) : v;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (vs > hi) begin
            return {1'b1, hi};
        end else if (vs < lo) begin
            return {1'b1, lo};
        end
        return {1'b0, vs};
    endfunction

endpackage

// File: rtl/butterfly_r2_param_core.sv
// Combinational butterfly: gate operands, add/sub at DW+1 bits, rotate the
// difference by a trivial twiddle, optionally halve, then clamp to DW bits.
module butterfly_r2_core
    import butterfly_r2_param_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 i_up_valid,
    input  logic signed [DW-1:0] i_up_r,
    input  logic signed [DW-1:0] i_up_i,
    input  logic                 i_down_valid,
    input  logic signed [DW-1:0] i_down_r,
    input  logic signed [DW-1:0] i_down_i,
    input  logic [1:0]           i_rot,
    input  logic                 i_scale,
    output logic signed [DW-1:0] o_add_r,
    output logic signed [DW-1:0] o_add_i,
    output logic signed [DW-1:0] o_sub_r,
    output logic signed [DW-1:0] o_sub_i,
    output logic                 o_add_ovf,
    output logic                 o_sub_ovf
);

    logic signed [DW:0] w_up_r, w_up_i, w_dn_r, w_dn_i;
    logic signed [DW:0] w_s_r, w_s_i, w_d_r, w_d_i;
    logic signed [DW:0] w_rot_r, w_rot_i;
    logic [SAT_MAXW:0]  w_res_add_r, w_res_add_i, w_res_sub_r, w_res_sub_i;

    assign w_up_r = i_up_valid   ? {i_up_r[DW-1], i_up_r}     : '0;
    assign w_up_i = i_up_valid   ? {i_up_i[DW-1], i_up_i}     : '0;
    assign w_dn_r = i_down_valid ? {i_down_r[DW-1], i_down_r} : '0;
    assign w_dn_i = i_down_valid ? {i_down_i[DW-1], i_down_i} : '0;

    assign w_s_r = w_up_r + w_dn_r;
    assign w_s_i = w_up_i + w_dn_i;
    assign w_d_r = w_up_r - w_dn_r;
    assign w_d_i = w_up_i - w_dn_i;

    // |D| <= 2^DW-1, so negation cannot overflow at DW+1 bits.
    always_comb begin
        w_rot_r = w_d_r;
        w_rot_i = w_d_i;
        case (rot_e'(i_rot))
            ROT_P1: begin w_rot_r = w_d_r;  w_rot_i = w_d_i;  end
            ROT_NI: begin w_rot_r = w_d_i;  w_rot_i = -w_d_r; end
            ROT_N1: begin w_rot_r = -w_d_r; w_rot_i = -w_d_i; end
            default: begin w_rot_r = -w_d_i; w_rot_i = w_d_r; end
        endcase
    end

    assign w_res_add_r = round_sat(SAT_MAXW'(w_s_r),   i_scale, DW);
    assign w_res_add_i = round_sat(SAT_MAXW'(w_s_i),   i_scale, DW);
    assign w_res_sub_r = round_sat(SAT_MAXW'(w_rot_r), i_scale, DW);
    assign w_res_sub_i = round_sat(SAT_MAXW'(w_rot_i), i_scale, DW);

    assign o_add_r   = w_res_add_r[DW-1:0];
    assign o_add_i   = w_res_add_i[DW-1:0];
    assign o_sub_r   = w_res_sub_r[DW-1:0];
    assign o_sub_i   = w_res_sub_i[DW-1:0];
    assign o_add_ovf = w_res_add_r[SAT_MAXW] | w_res_add_i[SAT_MAXW];
    assign o_sub_ovf = w_res_sub_r[SAT_MAXW] | w_res_sub_i[SAT_MAXW];

endmodule

// File: rtl/pipe_reg.sv
// Single-bit delay line exposing every stage, with synchronous clear of all stages.
module pipe_reg #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_d,
    output logic [DEPTH-1:0] o_q
);

    logic [DEPTH-1:0] r_q;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (i_clr) begin
                    r_q <= '0;
                end else begin
                    r_q <= i_d;
                end
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (i_clr) begin
                    r_q <= '0;
                end else begin
                    r_q <= {r_q[DEPTH-2:0], i_d};
                end
            end
        end
    endgenerate

    assign o_q = r_q;

endmodule

// File: rtl/butterfly_r2_param.sv
// Pipelined radix-2 butterfly: LAT register stages of sum/rotated-diff results
// with flushable valid line, sticky overflow flag and saturating event counter.
module butterfly_r2_param
    import butterfly_r2_param_pkg::*;
#(
    parameter int DW  = 16,
    parameter int LAT = 2,
    parameter int CW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_up_valid,
    input  logic signed [DW-1:0] i_up_r,
    input  logic signed [DW-1:0] i_up_i,
    input  logic                 i_down_valid,
    input  logic signed [DW-1:0] i_down_r,
    input  logic signed [DW-1:0] i_down_i,
    input  logic [1:0]           i_rot,
    input  logic                 i_scale,
    input  logic                 i_flush,
    input  logic                 i_ovf_clr,
    output logic                 o_add_valid,
    output logic signed [DW-1:0] o_add_r,
    output logic signed [DW-1:0] o_add_i,
    output logic                 o_sub_valid,
    output logic signed [DW-1:0] o_sub_r,
    output logic signed [DW-1:0] o_sub_i,
    output logic                 o_ovf_sticky,
    output logic [CW-1:0]        o_ovf_cnt
);

    localparam int PW = 4 * DW + 2;

    logic signed [DW-1:0] w_add_r, w_add_i, w_sub_r, w_sub_i;
    logic                 w_add_ovf, w_sub_ovf;
    logic                 w_vin;
    logic [PW-1:0]        w_pack;
    logic [LAT-1:0]       w_valid;
    logic [PW-1:0]        r_stage [LAT];
    logic                 w_add_ovf_out, w_sub_ovf_out, w_event;
    logic                 r_ovf_sticky;
    logic [CW-1:0]        r_ovf_cnt;

    butterfly_r2_core #(.DW(DW)) u_core (
        .i_up_valid   (i_up_valid),
        .i_up_r       (i_up_r),
        .i_up_i       (i_up_i),
        .i_down_valid (i_down_valid),
        .i_down_r     (i_down_r),
        .i_down_i     (i_down_i),
        .i_rot        (i_rot),
        .i_scale      (i_scale),
        .o_add_r      (w_add_r),
        .o_add_i      (w_add_i),
        .o_sub_r      (w_sub_r),
        .o_sub_i      (w_sub_i),
        .o_add_ovf    (w_add_ovf),
        .o_sub_ovf    (w_sub_ovf)
    );

    assign w_vin  = i_up_valid & i_down_valid;
    assign w_pack = {w_add_ovf, w_sub_ovf, w_add_r, w_add_i, w_sub_r, w_sub_i};

    pipe_reg #(.DEPTH(LAT)) u_valid_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (i_flush),
        .i_d   (w_vin),
        .o_q   (w_valid)
    );

    // Each stage loads only when the valid entering it is set; add and sub share one word.
    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic          w_en;
            logic [PW-1:0] w_din;
            if (gi == 0) begin : g_first
                assign w_en  = w_vin;
                assign w_din = w_pack;
            end else begin : g_rest
                assign w_en  = w_valid[gi-1];
                assign w_din = r_stage[gi-1];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage[gi] <= '0;
                end else if (w_en) begin
                    r_stage[gi] <= w_din;
                end
            end
        end
    endgenerate

    assign {w_add_ovf_out, w_sub_ovf_out, o_add_r, o_add_i, o_sub_r, o_sub_i} = r_stage[LAT-1];
    assign o_add_valid = w_valid[LAT-1];
    assign o_sub_valid = w_valid[LAT-1];

    assign w_event = (o_add_valid & w_add_ovf_out) | (o_sub_valid & w_sub_ovf_out);

    // A new event wins over a same-cycle clear, restarting the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_cnt    <= '0;
        end else if (w_event) begin
            r_ovf_sticky <= 1'b1;
            if (i_ovf_clr) begin
                r_ovf_cnt <= CW'(1);
            end else if (r_ovf_cnt != {CW{1'b1}}) begin
                r_ovf_cnt <= r_ovf_cnt + CW'(1);
            end
        end else if (i_ovf_clr) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_cnt    <= '0;
        end
    end

    assign o_ovf_sticky = r_ovf_sticky;
    assign o_ovf_cnt    = r_ovf_cnt;

endmodule
